// File: rtl/regfile_2r1w_param.sv
// Two-read/one-write register file with byte-enable writes and a write-to-read bypass.
// A clear sequencer zeroes the storage one entry per cycle.
module regfile_2r1w_param #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     wAddr,
    input  logic [DATA_W/8-1:0]   wBe,
    input  logic [DATA_W-1:0]     wData,
    input  logic                  re0,
    input  logic [ADDR_W-1:0]     rAddr0,
    output logic [DATA_W-1:0]     rData0,
    output logic                  rValid0,
    input  logic                  re1,
    input  logic [ADDR_W-1:0]     rAddr1,
    output logic [DATA_W-1:0]     rData1,
    output logic                  rValid1,
    input  logic                  clr,
    output logic                  busy
);

    localparam int                NB       = DATA_W / 8;
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   ptr_q, ptr_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];
    logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic                busy_q, busy_d;
    logic                write_ok;
    logic [DATA_W-1:0]   rsel0, rsel1;

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_X);
    endfunction

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_v,
        input logic [DATA_W-1:0] new_v,
        input logic [NB-1:0]     be
    );
        logic [DATA_W-1:0] res;
        res = old_v;
        for (int b = 0; b < NB; b++) begin
            if (be[b]) begin
                res[8*b +: 8] = new_v[8*b +: 8];
            end else begin
                res[8*b +: 8] = old_v[8*b +: 8];
            end
        end
        return res;
    endfunction

    // Clear sequencer next state: one entry per cycle, clr ignored while sweeping
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (clr) begin
                    state_d = ST_SWEEP;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_IDLE;
                    ptr_d   = ptr_q;
                end
            end
            ST_SWEEP: begin
                if (ptr_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    ptr_d   = '0;
                end else begin
                    state_d = ST_SWEEP;
                    ptr_d   = ptr_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                ptr_d   = '0;
            end
        endcase
        busy_d = (state_d == ST_SWEEP);
    end

    // Next storage image; reads sample this so they see same-edge writes and sweeps
    always_comb begin
        write_ok = we & (state_q == ST_IDLE) & ~clr & in_range(wAddr);
        for (int i = 0; i < DEPTH; i++) begin
            if (write_ok && (wAddr == ADDR_W'(i))) begin
                mem_d[i] = merge_bytes(mem_q[i], wData, wBe);
            end else if ((state_q == ST_SWEEP) && (ptr_q == ADDR_W'(i))) begin
                mem_d[i] = '0;
            end else begin
                mem_d[i] = mem_q[i];
            end
        end
    end

    // Read muxes; an address outside the array matches no entry and yields zero
    always_comb begin
        rsel0 = '0;
        rsel1 = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (rAddr0 == ADDR_W'(i)) begin
                rsel0 = mem_d[i];
            end else begin
                rsel0 = rsel0;
            end
            if (rAddr1 == ADDR_W'(i)) begin
                rsel1 = mem_d[i];
            end else begin
                rsel1 = rsel1;
            end
        end
        rdata0_d  = re0 ? rsel0 : rdata0_q;
        rdata1_d  = re1 ? rsel1 : rdata1_q;
        rvalid0_d = re0;
        rvalid1_d = re1;
    end

    // State, storage and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            busy_q    <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            busy_q    <= busy_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rData0  = rdata0_q;
    assign rData1  = rdata1_q;
    assign rValid0 = rvalid0_q;
    assign rValid1 = rvalid1_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_regfile_2r1w_param.sv
// Scoreboard bench for regfile_2r1w_param (DEPTH=6 to exercise out-of-range addresses).
module tb_regfile_2r1w_param;

    localparam int DW    = 32;
    localparam int DEPTH = 6;
    localparam int AW    = 3;
    localparam int NB    = DW / 8;

    logic          clk = 1'b0;
    logic          reset, we, re0, re1, clr;
    logic [AW-1:0] wAddr, rAddr0, rAddr1;
    logic [NB-1:0] wBe;
    logic [DW-1:0] wData;
    logic [DW-1:0] rData0, rData1;
    logic          rValid0, rValid1, busy;

    always #5 clk = ~clk;

    regfile_2r1w_param #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .we(we), .wAddr(wAddr), .wBe(wBe), .wData(wData),
        .re0(re0), .rAddr0(rAddr0), .rData0(rData0), .rValid0(rValid0),
        .re1(re1), .rAddr1(rAddr1), .rData1(rData1), .rValid1(rValid1),
        .clr(clr), .busy(busy)
    );

    typedef struct packed {
        logic rst;
        logic busy;
        logic v0;
        logic v1;
    } rec_t;

    rec_t          cyc_q[$];
    logic [DW-1:0] d0_q[$];
    logic [DW-1:0] d1_q[$];
    int            checks = 0;
    int            errors = 0;

    // Reference model: plain array plus a sweep flag and sweep index
    logic [DW-1:0] ref_mem [DEPTH];
    bit            ref_sweep = 1'b0;
    int            ref_ptr   = 0;
    logic [DW-1:0] last0 = '0;
    logic [DW-1:0] last1 = '0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Predict the effect of the coming clock edge from the current inputs
    task automatic model();
        rec_t          r;
        logic [DW-1:0] nxt [DEPTH];
        int            a;
        r = '0;
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            ref_sweep = 1'b0;
            ref_ptr   = 0;
            r.rst     = 1'b1;
        end else begin
            nxt = ref_mem;
            a   = int'(wAddr);
            if (we && !ref_sweep && !clr && a < DEPTH) begin
                for (int b = 0; b < NB; b++)
                    if (wBe[b]) nxt[a][8*b +: 8] = wData[8*b +: 8];
            end
            if (ref_sweep) begin
                nxt[ref_ptr] = '0;
                ref_ptr++;
                if (ref_ptr == DEPTH) begin
                    ref_sweep = 1'b0;
                    ref_ptr   = 0;
                end
            end else if (clr) begin
                ref_sweep = 1'b1;
                ref_ptr   = 0;
            end
            if (re0) begin
                r.v0 = 1'b1;
                a = int'(rAddr0);
                d0_q.push_back((a < DEPTH) ? nxt[a] : 32'h0000_0000);
            end
            if (re1) begin
                r.v1 = 1'b1;
                a = int'(rAddr1);
                d1_q.push_back((a < DEPTH) ? nxt[a] : 32'h0000_0000);
            end
            ref_mem = nxt;
        end
        r.busy = ref_sweep;
        cyc_q.push_back(r);
    endtask

    task automatic step();
        model();
        @(negedge clk);
        reset = 1'b0;
        we    = 1'b0;
        re0   = 1'b0;
        re1   = 1'b0;
        clr   = 1'b0;
    endtask

    task automatic set_wr(input int a, input logic [NB-1:0] be, input logic [DW-1:0] d);
        we    = 1'b1;
        wAddr = AW'(a);
        wBe   = be;
        wData = d;
    endtask

    task automatic set_rd(input int a0, input int a1);
        re0    = 1'b1;
        rAddr0 = AW'(a0);
        re1    = 1'b1;
        rAddr1 = AW'(a1);
    endtask

    // Monitor: pops one record per edge and the read data whenever a strobe appears
    initial begin
        rec_t r;
        forever begin
            @(posedge clk);
            #1;
            if (cyc_q.size() > 0) begin
                r = cyc_q.pop_front();
                if (r.rst) begin
                    last0 = '0;
                    last1 = '0;
                end
                check("busy", DW'(busy), DW'(r.busy));
                check("rValid0", DW'(rValid0), DW'(r.v0));
                check("rValid1", DW'(rValid1), DW'(r.v1));
                if (r.v0 && d0_q.size() > 0) last0 = d0_q.pop_front();
                if (r.v1 && d1_q.size() > 0) last1 = d1_q.pop_front();
                check(r.v0 ? "rData0" : "rData0_hold", rData0, last0);
                check(r.v1 ? "rData1" : "rData1_hold", rData1, last1);
            end
        end
    end

    initial begin
        reset = 1'b1; we = 1'b0; re0 = 1'b0; re1 = 1'b0; clr = 1'b0;
        wAddr = '0; wBe = '0; wData = '0; rAddr0 = '0; rAddr1 = '0;
        step();
        reset = 1'b1;
        step();

        // T1: full write then read on the next cycle
        set_wr(3, 4'hF, 32'hDEADBEEF); step();
        set_rd(3, 0); step();
        // T2: byte-enable merge
        set_wr(5, 4'hF, 32'h11223344); step();
        set_wr(5, 4'b0101, 32'hAABBCCDD); step();
        set_rd(5, 5); step();
        // T3: same-edge bypass on both ports, then partial bypass
        set_wr(2, 4'hF, 32'h12345678); set_rd(2, 2); step();
        set_wr(5, 4'b1000, 32'hFF00_0000); set_rd(5, 3); step();
        // T4: out-of-range write and read
        set_wr(7, 4'hF, 32'hCAFEF00D); step();
        set_wr(6, 4'hF, 32'hBADDCAFE); set_rd(7, 6); step();
        for (int i = 0; i < DEPTH; i += 2) begin set_rd(i, i + 1); step(); end
        // zero byte enables change nothing
        set_wr(3, 4'h0, 32'h0BAD_0BAD); set_rd(3, 3); step();

        // T5: fill, clr with a simultaneous write, writes and reads during the sweep
        for (int i = 0; i < DEPTH; i++) begin set_wr(i, 4'hF, $urandom); step(); end
        set_wr(1, 4'hF, 32'h5555_AAAA); clr = 1'b1; step();
        for (int i = 0; i < DEPTH; i++) begin
            set_wr(i, 4'hF, 32'hFFFF_FFFF); set_rd(i, DEPTH - 1 - i);
            if (i == 2) clr = 1'b1;
            step();
        end
        for (int i = 0; i < DEPTH; i += 2) begin set_rd(i, i + 1); step(); end

        // T6: reset mid-sweep, then a write must land
        for (int i = 0; i < DEPTH; i++) begin set_wr(i, 4'hF, 32'h0100_0000 + i); step(); end
        clr = 1'b1; step();
        step(); step();
        reset = 1'b1; step();
        set_wr(1, 4'hF, 32'h0F0F_1234); set_rd(0, 4); step();
        set_rd(1, 2); step();

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            reset  = ($urandom_range(0, 79) == 0);
            clr    = ($urandom_range(0, 24) == 0);
            we     = 1'($urandom_range(0, 1));
            wAddr  = AW'($urandom_range(0, 7));
            wBe    = NB'($urandom);
            wData  = $urandom;
            re0    = 1'($urandom_range(0, 1));
            rAddr0 = AW'($urandom_range(0, 7));
            re1    = 1'($urandom_range(0, 1));
            rAddr1 = (n % 5 == 0) ? rAddr0 : AW'($urandom_range(0, 7));
            if (n % 7 == 0) rAddr0 = wAddr;
            step();
        end

        step(); step();
        check("queues_drained", DW'(cyc_q.size() + d0_q.size() + d1_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
